one_hot_dec: RTL

Streaming one-hot-to-binary decoder for the LDPC derate-matching datapath, the inverse of the one-hot encoder used upstream. It accepts a `DATA_WIDTH-bit one-hot vector per beat under valid/ready flow control and returns the `D_WIDTH_LOG2-bit index after a two-stage pipeline. Malformed vectors are flagged per beat and tallied in a saturating error counter. It sits between the lane-select logic and the derate address generator.

---
 rtl/one_hot_dec_pkg.sv | 44 ++++
 rtl/one_hot_dec_grp.sv | 27 ++
 rtl/one_hot_dec.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/one_hot_dec_pkg.sv
// ============================================================================
// Module      : one_hot_dec_pkg
// Description : Shared constants, per-group decode record and the 8-bit
//               lowest-set-bit helper for the one-hot-to-binary decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package one_hot_dec_pkg;

    // Datapath defaults for the derate-matching lane
    localparam int c_data_width   = 64;
    localparam int c_d_width_log2 = 6;

    // Group decoder geometry and error counter width
    localparam int c_ohd_grp_w    = 8;
    localparam int c_grp_idx_w    = 3;
    localparam int c_ohd_cnt_w    = 16;

    // Result of decoding one 8-bit group, as held in stage 1
    typedef struct packed {
        logic                   any;
        logic [c_grp_idx_w-1:0] idx;
        logic                   multi;
    } grp_dec_t;

    // Position of the lowest set bit of an 8-bit group; 0 when none is set
    function automatic logic [c_grp_idx_w-1:0] lowest_set8(
        input logic [c_ohd_grp_w-1:0] v
    );
        logic [c_grp_idx_w-1:0] res;
        res = '0;
        // Scan downwards so the lowest set bit is the last one written
        for (int i = c_ohd_grp_w - 1; i >= 0; i--) begin
            if (v[i]) begin
                res = c_grp_idx_w'(i);
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/one_hot_dec_grp.sv
// ============================================================================
// Module      : one_hot_dec_grp
// Description : Combinational decoder for one 8-bit slice of the one-hot
//               vector: any-set, lowest set index and multi-set flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module one_hot_dec_grp
    import one_hot_dec_pkg::*;
(
    input  logic [c_ohd_grp_w-1:0] i_grp,
    output logic                   o_any,
    output logic [c_grp_idx_w-1:0] o_idx,
    output logic                   o_multi
);

    // Clearing the lowest set bit leaves something only if two or more were set
    always_comb begin
        o_any   = |i_grp;
        o_idx   = lowest_set8(i_grp);
        o_multi = |(i_grp & (i_grp - c_ohd_grp_w'(1)));
    end

endmodule

`default_nettype wire

// File: rtl/one_hot_dec.sv
// ============================================================================
// Module      : one_hot_dec
// Description : Two-stage streaming one-hot-to-binary decoder with
//               valid/ready flow control, per-beat malformed-vector flags
//               and a saturating error counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module one_hot_dec
    import one_hot_dec_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width,
    parameter int IDX_W      = c_d_width_log2,
    parameter int CNT_W      = c_ohd_cnt_w
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] one_hot_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_W-1:0]      idx_out,
    output logic                  err_zero,
    output logic                  err_multi,
    output logic [CNT_W-1:0]      err_cnt,
    input  logic                  clr_cnt
);

    localparam int c_num_grp = DATA_WIDTH / c_ohd_grp_w;

    // Raw group decodes straight from the input vector
    logic [c_num_grp-1:0]   w_any;
    logic [c_num_grp-1:0]   w_multi;
    logic [c_grp_idx_w-1:0] w_gidx [c_num_grp];

    // Stage 1: registered group decodes
    logic                   r_s1_valid;
    grp_dec_t               r_s1_grp [c_num_grp];

    // Stage 2: registered final result, driven straight to the outputs
    logic                   r_s2_valid;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_err_zero;
    logic                   r_err_multi;
    logic [CNT_W-1:0]       r_err_cnt;

    // Flow control and stage-2 combine
    logic                   w_s1_en;
    logic                   w_s2_en;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_err_zero;
    logic                   w_err_multi;
    logic                   w_any_seen;
    logic                   w_cnt_inc;

    // One decoder per 8-bit slice of the input
    generate
        for (genvar g = 0; g < c_num_grp; g++) begin : g_grp
            one_hot_dec_grp u_grp (
                .i_grp   (one_hot_in[g*c_ohd_grp_w +: c_ohd_grp_w]),
                .o_any   (w_any[g]),
                .o_idx   (w_gidx[g]),
                .o_multi (w_multi[g])
            );
        end
    endgenerate

    // A stage may load when it is empty or its content moves on this cycle
    assign w_s2_en  = ~r_s2_valid | out_ready;
    assign w_s1_en  = ~r_s1_valid | w_s2_en;
    assign in_ready = w_s1_en & rst_n;

    // Stage 1 captures the group decodes of an accepted beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            for (int g = 0; g < c_num_grp; g++) begin
                r_s1_grp[g] <= '0;
            end
        end else if (w_s1_en) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                for (int g = 0; g < c_num_grp; g++) begin
                    r_s1_grp[g] <= '{any: w_any[g], idx: w_gidx[g], multi: w_multi[g]};
                end
            end
        end
    end

    // Pick the lowest populated group and derive the malformed-beat flags
    always_comb begin
        w_idx       = '0;
        w_err_multi = 1'b0;
        w_any_seen  = 1'b0;
        for (int g = 0; g < c_num_grp; g++) begin
            if (r_s1_grp[g].any) begin
                if (w_any_seen) begin
                    w_err_multi = 1'b1;
                end else begin
                    w_idx = IDX_W'(g * c_ohd_grp_w + int'(r_s1_grp[g].idx));
                end
                w_any_seen = 1'b1;
            end
            if (r_s1_grp[g].multi) begin
                w_err_multi = 1'b1;
            end
        end
        w_err_zero = ~w_any_seen;
    end

    // Stage 2 holds the result steady while the output is stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid  <= 1'b0;
            r_idx       <= '0;
            r_err_zero  <= 1'b0;
            r_err_multi <= 1'b0;
        end else if (w_s2_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_idx       <= w_idx;
                r_err_zero  <= w_err_zero;
                r_err_multi <= w_err_multi;
            end
        end
    end

    assign w_cnt_inc = r_s2_valid & out_ready & (r_err_zero | r_err_multi);

    // Saturating count of erroneous output transfers; clear wins over a count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (clr_cnt) begin
            r_err_cnt <= '0;
        end else if (w_cnt_inc && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign out_valid = r_s2_valid;
    assign idx_out   = r_idx;
    assign err_zero  = r_err_zero;
    assign err_multi = r_err_multi;
    assign err_cnt   = r_err_cnt;

endmodule

`default_nettype wire
